// File: rtl/key_lookup_pkg.sv
// key_lookup shared definitions: default widths and the table entry layout.
// Optional hit/miss statistics are enabled with KEY_LOOKUP_STATS_EN.
package key_lookup_pkg;

  localparam int DEF_KEY_LEN  = 896;
  localparam int DEF_MASK_LEN = 896;
  localparam int DEF_PHV_LEN  = 1579;
  localparam int DEF_ACT_LEN  = 625;
  localparam int DEF_ENTRIES  = 16;
  localparam int ADDR_W       = $clog2(DEF_ENTRIES);

  typedef struct packed {
    logic                    vld;
    logic [DEF_KEY_LEN-1:0]  key;
    logic [DEF_MASK_LEN-1:0] mask;
    logic [DEF_ACT_LEN-1:0]  action;
  } entry_t;

endpackage

// File: rtl/key_lookup_prio_enc.sv
// Lowest-index priority encoder: hit vector -> {any, index}.
// Purely combinational; used in the last lookup stage.
module key_lookup_prio_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         any,
  output logic [W-1:0] idx
);

  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/key_lookup.sv
// Ternary key lookup: 3-stage masked match, lowest index wins.
// Define KEY_LOOKUP_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module key_lookup
  import key_lookup_pkg::*;
#(
  parameter int KEY_LEN  = DEF_KEY_LEN,
  parameter int MASK_LEN = DEF_MASK_LEN,
  parameter int PHV_LEN  = DEF_PHV_LEN,
  parameter int ENTRIES  = DEF_ENTRIES,
  parameter int ACT_LEN  = DEF_ACT_LEN,
  parameter int STAGE    = 0
) (
  input  logic                       axis_clk,
  input  logic                       aresetn,
  input  logic                       key_valid,
  input  logic [KEY_LEN-1:0]         extract_key,
  input  logic                       key_mask_valid,
  input  logic [MASK_LEN-1:0]        key_mask,
  input  logic                       cond_flag,
  input  logic [PHV_LEN-1:0]         pkt_hdr_vec,
  input  logic                       cfg_wr_en,
  input  logic [$clog2(ENTRIES)-1:0] cfg_wr_addr,
  input  logic                       cfg_wr_vld,
  input  logic [KEY_LEN-1:0]         cfg_wr_key,
  input  logic [MASK_LEN-1:0]        cfg_wr_mask,
  input  logic [ACT_LEN-1:0]         cfg_wr_action,
  output logic                       action_valid,
  output logic [ACT_LEN-1:0]         action,
  output logic                       hit,
  output logic [$clog2(ENTRIES)-1:0] match_addr,
  output logic [PHV_LEN-1:0]         pkt_hdr_vec_out
`ifdef KEY_LOOKUP_STATS_EN
  ,
  output logic [31:0]                hit_cnt,
  output logic [31:0]                miss_cnt
`endif
);

  localparam int AW = $clog2(ENTRIES);

  if (MASK_LEN != KEY_LEN || ENTRIES < 2 || STAGE < 0) begin : g_bad_cfg
    $error("key_lookup: bad parameters");
  end

  // table: valid bits are reset, contents are plain storage
  logic [ENTRIES-1:0] vld_q, vld_d;
  logic [KEY_LEN-1:0] tbl_key_q  [ENTRIES];
  logic [KEY_LEN-1:0] tbl_mask_q [ENTRIES];
  logic [ACT_LEN-1:0] tbl_act_q  [ENTRIES];

  logic               s0_vld_q, s0_vld_d;
  logic [KEY_LEN-1:0] s0_key_q, s0_key_d;
  logic [KEY_LEN-1:0] s0_kmask_q, s0_kmask_d;
  logic               s0_cond_q, s0_cond_d;
  logic [PHV_LEN-1:0] s0_phv_q, s0_phv_d;

  logic               s1_vld_q, s1_vld_d;
  logic [ENTRIES-1:0] s1_vec_q, s1_vec_d;
  logic [PHV_LEN-1:0] s1_phv_q, s1_phv_d;

  logic               av_q, av_d;
  logic               hit_q, hit_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [ACT_LEN-1:0] act_q, act_d;
  logic [PHV_LEN-1:0] phv_out_q, phv_out_d;

  logic [ENTRIES-1:0] match_vec;
  logic               enc_any;
  logic [AW-1:0]      enc_idx;
  logic               req;

  assign req = key_valid & key_mask_valid;

  always_comb begin
    vld_d = vld_q;
    if (cfg_wr_en) vld_d[cfg_wr_addr] = cfg_wr_vld;
  end

  always_ff @(posedge axis_clk) begin
    if (cfg_wr_en) begin
      tbl_key_q[cfg_wr_addr]  <= cfg_wr_key;
      tbl_mask_q[cfg_wr_addr] <= cfg_wr_mask;
      tbl_act_q[cfg_wr_addr]  <= cfg_wr_action;
    end
  end

  always_comb begin
    s0_vld_d   = req;
    s0_key_d   = s0_key_q;
    s0_kmask_d = s0_kmask_q;
    s0_cond_d  = s0_cond_q;
    s0_phv_d   = s0_phv_q;
    if (req) begin
      s0_key_d   = extract_key;
      s0_kmask_d = key_mask;
      s0_cond_d  = cond_flag;
      s0_phv_d   = pkt_hdr_vec;
    end
  end

  // compare against the table as it stands this cycle
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_vec[i] = vld_q[i] &&
        ~|((s0_key_q ^ tbl_key_q[i]) &
           tbl_mask_q[i] & s0_kmask_q);
    end
  end

  always_comb begin
    s1_vld_d = s0_vld_q;
    s1_vec_d = s1_vec_q;
    s1_phv_d = s1_phv_q;
    if (s0_vld_q) begin
      s1_vec_d = s0_cond_q ? match_vec : '0;
      s1_phv_d = s0_phv_q;
    end
  end

  key_lookup_prio_enc #(
    .N (ENTRIES),
    .W (AW)
  ) u_prio_enc (
    .vec (s1_vec_q),
    .any (enc_any),
    .idx (enc_idx)
  );

  always_comb begin
    av_d      = s1_vld_q;
    hit_d     = hit_q;
    addr_d    = addr_q;
    act_d     = act_q;
    phv_out_d = phv_out_q;
    if (s1_vld_q) begin
      hit_d     = enc_any;
      addr_d    = enc_any ? enc_idx : '0;
      act_d     = enc_any ? tbl_act_q[enc_idx] : '0;
      phv_out_d = s1_phv_q;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q      <= '0;
      s0_vld_q   <= 1'b0;
      s0_key_q   <= '0;
      s0_kmask_q <= '0;
      s0_cond_q  <= 1'b0;
      s0_phv_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_vec_q   <= '0;
      s1_phv_q   <= '0;
      av_q       <= 1'b0;
      hit_q      <= 1'b0;
      addr_q     <= '0;
      act_q      <= '0;
      phv_out_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      s0_vld_q   <= s0_vld_d;
      s0_key_q   <= s0_key_d;
      s0_kmask_q <= s0_kmask_d;
      s0_cond_q  <= s0_cond_d;
      s0_phv_q   <= s0_phv_d;
      s1_vld_q   <= s1_vld_d;
      s1_vec_q   <= s1_vec_d;
      s1_phv_q   <= s1_phv_d;
      av_q       <= av_d;
      hit_q      <= hit_d;
      addr_q     <= addr_d;
      act_q      <= act_d;
      phv_out_q  <= phv_out_d;
    end
  end

  assign action_valid    = av_q;
  assign hit             = hit_q;
  assign match_addr      = addr_q;
  assign action          = act_q;
  assign pkt_hdr_vec_out = phv_out_q;

`ifdef KEY_LOOKUP_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // counted as the result registers, so counts track the outputs
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (s1_vld_q) begin
      if (enc_any && hit_cnt_q != '1)
        hit_cnt_d = hit_cnt_q + 32'd1;
      if (!enc_any && miss_cnt_q != '1)
        miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
